fft256_final_stage: RTL
=======================

# fft256_final_stage

Final two-butterfly stage of the 256-point radix-2^2 single-path delay-feedback FFT, directly downstream of stage 6 (the delay-4 butterfly plus twiddle multiplier). It consumes stage-6 output frames and performs the last two butterfly levels: a delay-2 butterfly, a trivial -j rotation, then a delay-1 butterfly. No twiddle multiplier is used. Output is the complete FFT frame in bit-reversed order with 1/4 scaling.

## Interface
- WIDTH, 16, two's-complement data width per real/imag component
- clock  in  1  master clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- di_en  in  1  input valid; high for 256 contiguous cycles per frame
- di_re  in  WIDTH  input sample, real part
- di_im  in  WIDTH  input sample, imag part
- do_en  out  1  output valid; high for 256 contiguous cycles per frame
- do_re  out  WIDTH  output sample, real part, registered
- do_im  out  WIDTH  output sample, imag part, registered

## Operation
- Input counter di_count (8 bits):
  - increments while di_en is high;
  - cleared whenever di_en is low;
  - wraps 255->0.
- Butterfly arithmetic:
  - Sum and difference are formed at WIDTH+1 bits, then y = (s + RH) >>> 1, truncated to WIDTH.
  - Stage A uses RH=0 (floor). Stage B uses RH=1 (round half up).
  - y0 = (x0+x1) form, y1 = (x0-x1) form.
- Stage A (2-deep delay line, select = di_count[1]):
  - select=0: input goes into the delay line; the delay output is emitted.
  - select=1: x0 = delay output, x1 = input. y0 is emitted; y1 goes into the delay line.
- Stage A control:
  - a_en is set when (di_count==1 & di_en).
  - a_en is cleared when a_count==255. Set has priority over clear.
  - a_count increments while a_en is high, otherwise it is held at 0.
  - The emitted sample is registered into a_do.
  - a_do_en is a_en delayed by one cycle.
- -j rotation on a_do, applied when the a_do sample index [1:0]==3:
  - re' = im, im' = -re.
  - -(-2^(WIDTH-1)) saturates to 2^(WIDTH-1)-1.
  - All other samples pass through unchanged.
- Stage B (1-deep delay, select = b_count_in[0], counted on a_do_en):
  - Same structure and control as stage A, with the set condition (b_count_in==0 & a_do_en).
  - The emitted sample is registered to do_re/do_im. do_en is the registered stage-B enable.
- Per 4-sample input block [x0,x1,x2,x3], the output order is X0,X2,X1,X3, where Xk = DFT4(x)/4 subject to the rounding above.
- Back-to-back frames: the counters wrap and the enables stay high, so do_en is continuous.
- di_en dropping mid-frame aborts the frame:
  - counters restart;
  - the already-started output enables still run to 256 cycles;
  - data in the aborted portion is don't-care.

## Timing
- Reset: all counters, enables, a_do, do_en, do_re and do_im are 0 from the first edge where reset is sampled high.
- Reset takes effect mid-frame the same way: the partial frame is discarded and do_en=0 on the next cycle.
- After reset is released, the block waits for a fresh di_en run.
- Latency: first input sample at cycle 0 -> do_en first high at cycle 5.
  - Stage A: butterfly at cycle 2, registered at cycle 3.
  - Stage B: butterfly at cycle 4, registered at cycle 5.
- A frame input over cycles 0..255 produces do_en high over cycles 5..260.
- There is no backpressure. The downstream block must accept every do_en cycle.

## Test plan
- Impulse: di_re=1000 at sample 0, all other samples 0, imag 0 -> outputs 0..3 = 250+0j; outputs 4..255 = 0; do_en high over cycles 5..260.
- DC: all 256 samples 400+0j -> every 4-output block = 400, 0, 0, 0 (imag 0).
- -j path: block [0,800,0,0] -> outputs 200+0j, -200+0j, 0-200j, 0+200j.
- Rounding: block [3,0,0,0] -> stage A emits [1,0,1,0]; outputs are 1,1,1,1.
- Saturation: block x1=-32768, x3=32767 -> the -j negation saturates to 32767 with no wrap.
- Two frames back-to-back (di_en high over cycles 0..511) -> do_en continuous over cycles 5..516 and the second frame is correct.
- Reset asserted at cycle 100 of a frame -> do_en=0 from cycle 101. A new frame started after reset has latency 5 and correct data.

Source files
------------

// File: rtl/fft256_final_stage.sv
// fft256_final_stage
//   Last two butterfly levels of a 256-point radix-2^2 single-path
//   delay-feedback FFT: delay-2 butterfly (floor scaling), -j rotation on
//   every fourth sample, delay-1 butterfly (round-half-up scaling).
//   Output frame is bit-reversed with an overall 1/4 scaling.
//   Latency from first input sample to first output sample is 5 cycles.
//
// Ports
//   clock         rising-edge clock for all state
//   reset         synchronous, active-high reset
//   di_en         input valid, 256 contiguous cycles per frame
//   di_re/di_im   input sample (two's complement)
//   do_en         output valid, 256 contiguous cycles per frame
//   do_re/do_im   output sample, registered
module fft256_final_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH:0] sext(input logic [WIDTH-1:0] x);
    return {x[WIDTH-1], x};
  endfunction

  // (s + rh) >>> 1, keeping the low WIDTH bits of the shifted result
  function automatic logic [WIDTH-1:0] half(input logic [WIDTH:0] s, input logic rh);
    logic [WIDTH:0] t;
    t = s + {{WIDTH{1'b0}}, rh};
    return t[WIDTH:1];
  endfunction

  function automatic logic [WIDTH-1:0] neg_sat(input logic [WIDTH-1:0] x);
    return (x == MOST_NEG) ? MOST_POS : (~x + ONE_W);
  endfunction

  // input counter
  logic [7:0]             di_count_q, di_count_d;

  // stage A (delay 2)
  logic [1:0][WIDTH-1:0]  a_dl_re_q, a_dl_re_d;
  logic [1:0][WIDTH-1:0]  a_dl_im_q, a_dl_im_d;
  logic                   a_en_q, a_en_d;
  logic [7:0]             a_count_q, a_count_d;
  logic [WIDTH-1:0]       a_do_re_q, a_do_re_d;
  logic [WIDTH-1:0]       a_do_im_q, a_do_im_d;
  logic [1:0]             a_do_idx_q, a_do_idx_d;
  logic                   a_do_en_q, a_do_en_d;

  // stage B (delay 1)
  logic [7:0]             b_count_in_q, b_count_in_d;
  logic [WIDTH-1:0]       b_dl_re_q, b_dl_re_d;
  logic [WIDTH-1:0]       b_dl_im_q, b_dl_im_d;
  logic                   b_en_q, b_en_d;
  logic [7:0]             b_count_q, b_count_d;
  logic                   do_en_q, do_en_d;
  logic [WIDTH-1:0]       do_re_q, do_re_d;
  logic [WIDTH-1:0]       do_im_q, do_im_d;

  // combinational intermediates
  logic                   a_sel, b_sel;
  logic [WIDTH-1:0]       a_y0_re, a_y0_im, a_y1_re, a_y1_im;
  logic [WIDTH-1:0]       rot_re, rot_im;
  logic [WIDTH-1:0]       b_y0_re, b_y0_im, b_y1_re, b_y1_im;

  always_comb begin
    di_count_d = di_en ? di_count_q + 8'd1 : 8'd0;

    // ---- stage A: x0 = sample two cycles back, x1 = current input
    a_sel   = di_count_q[1];
    a_y0_re = half(sext(a_dl_re_q[1]) + sext(di_re), 1'b0);
    a_y0_im = half(sext(a_dl_im_q[1]) + sext(di_im), 1'b0);
    a_y1_re = half(sext(a_dl_re_q[1]) - sext(di_re), 1'b0);
    a_y1_im = half(sext(a_dl_im_q[1]) - sext(di_im), 1'b0);

    a_dl_re_d = {a_dl_re_q[0], (a_sel ? a_y1_re : di_re)};
    a_dl_im_d = {a_dl_im_q[0], (a_sel ? a_y1_im : di_im)};

    a_en_d = a_en_q;
    if (a_count_q == 8'd255) a_en_d = 1'b0;
    if (di_en && (di_count_q == 8'd1)) a_en_d = 1'b1;   // set wins over clear
    a_count_d = a_en_q ? a_count_q + 8'd1 : 8'd0;

    a_do_re_d  = a_sel ? a_y0_re : a_dl_re_q[1];
    a_do_im_d  = a_sel ? a_y0_im : a_dl_im_q[1];
    a_do_idx_d = a_count_q[1:0];
    a_do_en_d  = a_en_q;

    // ---- -j rotation on the fourth sample of each stage-A block
    rot_re = a_do_re_q;
    rot_im = a_do_im_q;
    if (a_do_idx_q == 2'd3) begin
      rot_re = a_do_im_q;
      rot_im = neg_sat(a_do_re_q);
    end

    // ---- stage B: x0 = previous rotated sample, x1 = current one
    b_count_in_d = a_do_en_q ? b_count_in_q + 8'd1 : 8'd0;
    b_sel   = b_count_in_q[0];
    b_y0_re = half(sext(b_dl_re_q) + sext(rot_re), 1'b1);
    b_y0_im = half(sext(b_dl_im_q) + sext(rot_im), 1'b1);
    b_y1_re = half(sext(b_dl_re_q) - sext(rot_re), 1'b1);
    b_y1_im = half(sext(b_dl_im_q) - sext(rot_im), 1'b1);

    b_dl_re_d = b_sel ? b_y1_re : rot_re;
    b_dl_im_d = b_sel ? b_y1_im : rot_im;

    b_en_d = b_en_q;
    if (b_count_q == 8'd255) b_en_d = 1'b0;
    if (a_do_en_q && (b_count_in_q == 8'd0)) b_en_d = 1'b1;
    b_count_d = b_en_q ? b_count_q + 8'd1 : 8'd0;

    do_en_d = b_en_q;
    do_re_d = b_sel ? b_y0_re : b_dl_re_q;
    do_im_d = b_sel ? b_y0_im : b_dl_im_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      di_count_q   <= '0;
      a_dl_re_q    <= '0;
      a_dl_im_q    <= '0;
      a_en_q       <= 1'b0;
      a_count_q    <= '0;
      a_do_re_q    <= '0;
      a_do_im_q    <= '0;
      a_do_idx_q   <= '0;
      a_do_en_q    <= 1'b0;
      b_count_in_q <= '0;
      b_dl_re_q    <= '0;
      b_dl_im_q    <= '0;
      b_en_q       <= 1'b0;
      b_count_q    <= '0;
      do_en_q      <= 1'b0;
      do_re_q      <= '0;
      do_im_q      <= '0;
    end else begin
      di_count_q   <= di_count_d;
      a_dl_re_q    <= a_dl_re_d;
      a_dl_im_q    <= a_dl_im_d;
      a_en_q       <= a_en_d;
      a_count_q    <= a_count_d;
      a_do_re_q    <= a_do_re_d;
      a_do_im_q    <= a_do_im_d;
      a_do_idx_q   <= a_do_idx_d;
      a_do_en_q    <= a_do_en_d;
      b_count_in_q <= b_count_in_d;
      b_dl_re_q    <= b_dl_re_d;
      b_dl_im_q    <= b_dl_im_d;
      b_en_q       <= b_en_d;
      b_count_q    <= b_count_d;
      do_en_q      <= do_en_d;
      do_re_q      <= do_re_d;
      do_im_q      <= do_im_d;
    end
  end

  assign do_en = do_en_q;
  assign do_re = do_re_q;
  assign do_im = do_im_q;

endmodule
